seq_encoder_16to4: RTL and testbench

Sequential 16-to-4 priority encoder; the inverse of the lab's 4-to-16 enabled decoder. It captures a 16-bit multi-hot request word and emits, one per accepted handshake, the 4-bit index of every set bit, highest index first. Its output code feeds the decoder's W input directly, so the two blocks round-trip in the lab top-level.

---
 rtl/seq_encoder_16to4_pkg.sv | 25 ++
 rtl/seq_encoder_16to4_prio_enc16.sv | 22 ++
 rtl/seq_encoder_16to4.sv | 111 +++++++++++
 tb/tb_seq_encoder_16to4.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_encoder_16to4_pkg.sv
// Shared definitions for the sequential 16-to-4 encoder: FSM state encoding and width defaults.
// SEQ_ENCODER_COUNT_EN adds the popcount helper used by the optional count output.
package seq_encoder_16to4_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef SEQ_ENCODER_COUNT_EN
    function automatic logic [DEF_CODE_W:0] popcount(input logic [DEF_WIDTH-1:0] w);
        logic [DEF_CODE_W:0] pc;
        pc = '0;
        for (int unsigned i = 0; i < DEF_WIDTH; i++) begin
            pc = pc + {{DEF_CODE_W{1'b0}}, w[i]};
        end
        return pc;
    endfunction
`endif

endpackage

// File: rtl/seq_encoder_16to4_prio_enc16.sv
// Combinational highest-set-bit finder: code is the index of the top set bit, any flags a non-empty word.
module prio_enc16 #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CODE_W = 4
) (
    input  logic [WIDTH-1:0]  pending,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    always_comb begin
        code = '0;
        // Ascending scan so the highest set index wins.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pending[i]) begin
                code = CODE_W'(i);
            end
        end
        any = |pending;
    end

endmodule

// File: rtl/seq_encoder_16to4.sv
// Sequential 16-to-4 priority encoder: emits the index of every set request bit, highest first.
// Defining SEQ_ENCODER_COUNT_EN adds a count output tracking the number of codes still pending.
module seq_encoder_16to4
    import seq_encoder_16to4_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned CODE_W = DEF_CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              En,
    input  logic              load,
    input  logic [WIDTH-1:0]  W,
    output logic              in_ready,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              out_ready,
    output logic              done,
    output logic              empty
`ifdef SEQ_ENCODER_COUNT_EN
    ,
    output logic [CODE_W:0]   count
`endif
);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   pending, pending_nx;
    logic [WIDTH-1:0]   cleared;
    logic               empty_nx;
    logic [CODE_W-1:0]  enc_code;
    logic               enc_any;
    logic               accept_load;
    logic               accept_code;

    prio_enc16 #(
        .WIDTH  (WIDTH),
        .CODE_W (CODE_W)
    ) u_prio (
        .pending (pending),
        .code    (enc_code),
        .any     (enc_any)
    );

    assign cleared = pending & ~(WIDTH'(1) << enc_code);

    // En=0 leaves every next-value equal to the current one, which freezes the block.
    always_comb begin
        state_nx    = state;
        pending_nx  = pending;
        empty_nx    = empty;
        in_ready    = 1'b0;
        valid       = 1'b0;
        done        = 1'b0;
        accept_load = 1'b0;
        accept_code = 1'b0;
        if (En) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (load) begin
                        accept_load = 1'b1;
                        pending_nx  = W;
                        empty_nx    = (W == '0);
                        state_nx    = (W == '0) ? DONE : EMIT;
                    end
                end
                EMIT: begin
                    valid = enc_any;
                    if (out_ready && enc_any) begin
                        accept_code = 1'b1;
                        pending_nx  = cleared;
                        if (cleared == '0) begin
                            state_nx = DONE;
                        end
                    end
                end
                DONE: begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
        code = valid ? enc_code : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            empty   <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            empty   <= empty_nx;
        end
    end

`ifdef SEQ_ENCODER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (accept_load) begin
            count <= popcount(W);
        end else if (accept_code) begin
            count <= count - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_encoder_16to4.sv
// Scoreboard bench for seq_encoder_16to4: stimulus queues expected codes/done, a monitor pops and compares.
module tb_seq_encoder_16to4;

    logic        clk = 1'b0;
    logic        rst, En, load, out_ready;
    logic [15:0] W;
    logic        in_ready, valid, done, empty;
    logic [3:0]  code;
`ifdef SEQ_ENCODER_COUNT_EN
    logic [4:0]  count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];            // expected code, or -1 for a done pulse
    logic [15:0] acc_or = '0;
    logic        prev_hold = 1'b0;
    logic [3:0]  prev_code = '0;

    seq_encoder_16to4 dut (
        .clk       (clk),
        .rst       (rst),
        .En        (En),
        .load      (load),
        .W         (W),
        .in_ready  (in_ready),
        .code      (code),
        .valid     (valid),
        .out_ready (out_ready),
        .done      (done),
        .empty     (empty)
`ifdef SEQ_ENCODER_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dec4to16(input logic en, input logic [3:0] w);
        return en ? (16'd1 << w) : 16'd0;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT hands over a code or pulses done.
    always @(negedge clk) begin
        int e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (!valid) check("code_zero_when_invalid", 32'(code), 32'd0);
            if (valid && prev_hold) check("code_held_stable", 32'(code), 32'(prev_code));
            if (valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_code actual=%0d required=none", code);
                end else begin
                    e = exp_q.pop_front();
                    check("code_order", 32'(code), 32'(e));
                end
                acc_or = acc_or | dec4to16(1'b1, code);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=done required=none");
                end else begin
                    e = exp_q.pop_front();
                    check("done_order", 32'(e), 32'hFFFF_FFFF);
                end
            end
            prev_hold = valid && !out_ready;
            prev_code = code;
        end
    end

    task automatic do_load(input logic [15:0] w);
        W    = w;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (in_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout actual=busy required=idle_drained", name);
        end
    endtask

    initial begin
        rst = 1'b1; En = 1'b1; load = 1'b0; W = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_empty", 32'(empty), 32'd0);
        check("rst_code", 32'(code), 32'd0);
        rst = 1'b0;
        tick();

        // Empty word: straight to done, no code.
        exp_q.push_back(-1);
        do_load(16'h0000);
        check("empty_done", 32'(done), 32'd1);
        check("empty_valid", 32'(valid), 32'd0);
        check("empty_flag", 32'(empty), 32'd1);
        check("empty_busy", 32'(in_ready), 32'd0);
        tick();
        check("empty_back_idle", 32'(in_ready), 32'd1);
        check("empty_done_once", 32'(done), 32'd0);
        check("empty_sticky", 32'(empty), 32'd1);

        // 15, 5, 2 back to back; a load during EMIT must be ignored.
        exp_q.push_back(15); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(-1);
        do_load(16'b1000_0000_0010_0100);
        check("t2_first_valid", 32'(valid), 32'd1);
        check("t2_first_code", 32'(code), 32'd15);
        check("t2_empty_clear", 32'(empty), 32'd0);
`ifdef SEQ_ENCODER_COUNT_EN
        check("t2_count_load", 32'(count), 32'd3);
`endif
        W = 16'h0F0F; load = 1'b1;
        tick();
        load = 1'b0;
        check("t2_second_code", 32'(code), 32'd5);
        tick();
        check("t2_third_code", 32'(code), 32'd2);
        tick();
        check("t2_done", 32'(done), 32'd1);
`ifdef SEQ_ENCODER_COUNT_EN
        check("t2_count_zero", 32'(count), 32'd0);
`endif
        wait_idle("t2");

        // All ones with out_ready toggling every cycle.
        for (int i = 15; i >= 0; i--) exp_q.push_back(i);
        exp_q.push_back(-1);
        do_load(16'hFFFF);
        for (int i = 0; i < 60; i++) begin
            if (in_ready && exp_q.size() == 0) break;
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t3");

        // Freeze after the first code.
        exp_q.push_back(8); exp_q.push_back(0); exp_q.push_back(-1);
        do_load(16'h0101);
        check("t4_code8", 32'(code), 32'd8);
        tick();
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_frz_valid", 32'(valid), 32'd0);
            check("t4_frz_done", 32'(done), 32'd0);
            check("t4_frz_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        En = 1'b1;
        #1;
        check("t4_resume_valid", 32'(valid), 32'd1);
        check("t4_resume_code", 32'(code), 32'd0);
        wait_idle("t4");

        // Reset in the middle of emission.
        exp_q.push_back(7);
        do_load(16'h00F0);
        tick();
        check("t5_code6_shown", 32'(code), 32'd6);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_idle", 32'(in_ready), 32'd1);
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        tick();
        check("t5_no_done", 32'(done), 32'd0);
        out_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(-1);
        do_load(16'h0001);
        check("t5_fresh_code", 32'(code), 32'd0);
        check("t5_fresh_valid", 32'(valid), 32'd1);
        wait_idle("t5");

        // Loopback through a 4-to-16 decoder model.
        acc_or = '0;
        exp_q.push_back(15); exp_q.push_back(13); exp_q.push_back(10); exp_q.push_back(8);
        exp_q.push_back(7);  exp_q.push_back(6);  exp_q.push_back(1);  exp_q.push_back(0);
        exp_q.push_back(-1);
        do_load(16'hA5C3);
        wait_idle("t6");
        check("loopback_or", 32'(acc_or), 32'h0000_A5C3);

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
